xcorr_peak_find: RTL and testbench
==================================

# xcorr_peak_find

Streaming peak detector downstream of the correlation engine. Consumes the 2N−1 correlation results in index order over a valid/ready handshake, tracks the largest value and its index, and reports the peak value, the signed lag (index − (N−1)), and a threshold-detect flag. The top-level controller uses the lag as the time-delay estimate between the two captured channels.

## Interface
- `N`, default 2000: samples per input channel; result count is `NUM_RES = 2*N-1` (3999).
- `DATA_W`, default 32: width of one signed correlation result.
- `IDX_W`, default `$clog2(2*N-1)`: result index width (12).
- `LAG_W`, default `IDX_W+1`: signed lag width (13).
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse to begin a scan; honoured only in IDLE.
- `threshold`  in  DATA_W  signed detect threshold, sampled on the accepted `start`.
- `in_data`  in  DATA_W  signed correlation result.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  marks the producer's final result.
- `in_ready`  out  1  block accepts data; high only in SCAN.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `peak_val`  out  DATA_W  best value, signed (magnitude when `PEAK_ABS_EN` is set).
- `peak_lag`  out  LAG_W  signed lag of the best value.
- `found`  out  1  `peak_val >= threshold` (signed compare).
- `err`  out  1  length mismatch between `in_last` and `NUM_RES`.

## Operation
- FSM states:
  - IDLE: on `start`, latch `threshold`, clear `cnt`, `found` and `err`, then go to SCAN.
  - SCAN: transfer on `in_valid && in_ready`; leave when `cnt == NUM_RES-1` or `in_last` transfers.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Per transfer, with `cnt` as the index of the current sample:
  - If `cnt == 0`, or the comparison value is strictly greater than `best`, load `best` and set `best_idx = cnt`.
  - Ties keep the earliest index.
  - Increment `cnt`.
- `peak_lag = $signed({1'b0,best_idx}) - (N-1)`. Range is −(N−1)..+(N−1).
- `err` is set when `in_last` arrives with `cnt != NUM_RES-1` (early termination; the scan ends with the partial result).
- `err` is also set when the transfer at `cnt == NUM_RES-1` arrives without `in_last`. That scan still ends normally.
- `peak_val`, `peak_lag`, `found` and `err` are updated on entry to DONE and held until the next accepted `start`.
- `start` during SCAN or DONE is ignored.
- `in_valid` outside SCAN is ignored; no data is consumed.
- Reset mid-scan: return to IDLE immediately. All outputs and internal state take their reset values.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `peak_val`=0, `peak_lag`=0, `found`=0, `err`=0, state IDLE.
- `start` at cycle T gives SCAN with `in_ready`=1 at T+1.
- Throughput is one result per cycle while `in_valid` is held.
- The final transfer at cycle F gives DONE at F+1: `done`=1, outputs valid, `in_ready`=0.
- The block is back in IDLE at F+2, so a new `start` is accepted at F+2.
- The compare/update path is a single registered stage, with no extra pipeline latency.
- `in_ready` is a registered state decode; it has no combinational dependency on `in_valid`.

## Configuration
- `XCORR_PEAK_ABS_EN` defined:
  - The compare uses `|in_data|`. The most-negative input saturates to `2^(DATA_W-1)-1`.
  - `peak_val` reports that magnitude.
  - `found` compares the magnitude against `threshold`.
  - This detects anti-correlated (inverted) channels.
- `XCORR_PEAK_ABS_EN` undefined: plain signed compare on `in_data`; the abs logic is not instantiated.

## Test plan
- **Peak at centre.** N=4 (NUM_RES=7), stream 1,2,3,9,3,2,1 with `in_last` on the 7th → `peak_val`=9, `peak_lag`=0, `done` one cycle after the last transfer, `err`=0.
- **Edge peaks and tie.** Stream 9,0,0,0,0,0,0 → `peak_lag`=−3. Stream 0,…,0,9 → `peak_lag`=+3. Stream 5,7,7,1,1,1,1 → `peak_lag`=−2 (first index wins).
- **Threshold and negatives.** All inputs −5 except −1 at index 4, `threshold`=0 → `peak_val`=−1, `peak_lag`=+1, `found`=0. Repeat with `threshold`=−2 → `found`=1.
- **Abs mode.** With `XCORR_PEAK_ABS_EN`, stream 3,−12,4,0,0,0,0 → `peak_val`=12, `peak_lag`=−2. Most-negative input → `peak_val`=`2^(DATA_W-1)-1`.
- **Length mismatch and backpressure.**
  - `in_last` on the 5th sample → `done`, `err`=1, peak taken over 5 samples.
  - 7 samples without `in_last` → `err`=1.
  - Random `in_valid` gaps do not change the result.
- **Reset and ignored start.**
  - `reset_n` low mid-scan → all outputs 0 and state IDLE within the same cycle.
  - `start` pulsed during SCAN does not restart the count.

Source files
------------

// File: rtl/xcorr_peak_find_if.sv
// Correlation-result stream from the correlation engine into xcorr_peak_find.
// Handshake: a result transfers on a rising clk edge where in_valid && in_ready;
// the producer holds in_data/in_last stable while in_valid is high and in_ready is low.
interface xcorr_peak_find_if #(
    parameter int DATA_W = 32
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;

    modport master (output in_data, output in_valid, output in_last, input  in_ready);
    modport slave  (input  in_data, input  in_valid, input  in_last, output in_ready);
endinterface

// File: rtl/xcorr_peak_find.sv
// Streaming peak/lag finder over 2N-1 correlation results with threshold detect.
// Define XCORR_PEAK_ABS_EN to rank results by saturated magnitude instead of signed value.
module xcorr_peak_find #(
    parameter int N      = 2000,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(2*N-1),
    parameter int LAG_W  = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] threshold,
    xcorr_peak_find_if.slave         in_if,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] peak_val,
    output logic signed [LAG_W-1:0]  peak_lag,
    output logic                     found,
    output logic                     err,
    output logic [1:0]               dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               NUM_RES  = 2*N - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic signed [DATA_W-1:0] thr_q, thr_d;
    logic signed [DATA_W-1:0] peak_val_q, peak_val_d;
    logic signed [LAG_W-1:0]  peak_lag_q, peak_lag_d;
    logic                     found_q, found_d;
    logic                     err_q, err_d;

    logic signed [DATA_W-1:0] cmp_val;
    logic signed [DATA_W-1:0] nb_val;
    logic [IDX_W-1:0]         nb_idx;
    logic                     xfer, take, last_idx;

`ifdef XCORR_PEAK_ABS_EN
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    // Negating the most-negative value would wrap, so it saturates instead.
    always_comb begin
        cmp_val = in_if.in_data;
        if (in_if.in_data == MOST_NEG)
            cmp_val = MAX_POS;
        else if (in_if.in_data[DATA_W-1])
            cmp_val = -in_if.in_data;
    end
`else
    assign cmp_val = in_if.in_data;
`endif

    assign xfer     = (state_q == S_SCAN) && in_if.in_valid;
    assign last_idx = (cnt_q == LAST_IDX);
    // Strict greater-than keeps the earliest index on ties.
    assign take     = (cnt_q == '0) || (cmp_val > best_q);
    assign nb_val   = take ? cmp_val : best_q;
    assign nb_idx   = take ? cnt_q : best_idx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        thr_d      = thr_q;
        peak_val_d = peak_val_q;
        peak_lag_d = peak_lag_q;
        found_d    = found_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d   = threshold;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (xfer) begin
                    best_d     = nb_val;
                    best_idx_d = nb_idx;
                    cnt_d      = cnt_q + IDX_W'(1);
                    if (last_idx || in_if.in_last) begin
                        state_d    = S_DONE;
                        peak_val_d = nb_val;
                        peak_lag_d = LAG_W'({1'b0, nb_idx}) - LAG_W'(N - 1);
                        found_d    = (nb_val >= thr_q);
                        err_d      = (last_idx != in_if.in_last);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            thr_q      <= '0;
            peak_val_q <= '0;
            peak_lag_q <= '0;
            found_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            thr_q      <= thr_d;
            peak_val_q <= peak_val_d;
            peak_lag_q <= peak_lag_d;
            found_q    <= found_d;
            err_q      <= err_d;
        end
    end

    assign in_if.in_ready = (state_q == S_SCAN);
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign peak_val       = peak_val_q;
    assign peak_lag       = peak_lag_q;
    assign found          = found_q;
    assign err            = err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_xcorr_peak_find.sv
// Directed bench for xcorr_peak_find with N=4 (seven results per scan).
// Expected peak/lag/found/err are hand-computed per vector; abs-mode vectors build under XCORR_PEAK_ABS_EN.
module tb_xcorr_peak_find;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int LW = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] threshold = '0;
    logic                 busy, done, found, err;
    logic signed [DW-1:0] peak_val;
    logic signed [LW-1:0] peak_lag;
    logic [1:0]           dbg_state;

    xcorr_peak_find_if #(.DATA_W(DW)) bus ();

    xcorr_peak_find #(.N(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .threshold (threshold),
        .in_if     (bus),
        .busy      (busy),
        .done      (done),
        .peak_val  (peak_val),
        .peak_lag  (peak_lag),
        .found     (found),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [DW-1:0] vec [0:6];
    logic [DW+LW+1:0]     exp_q [$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6);
        vec[0] = DW'(v0); vec[1] = DW'(v1); vec[2] = DW'(v2); vec[3] = DW'(v3);
        vec[4] = DW'(v4); vec[5] = DW'(v5); vec[6] = DW'(v6);
    endtask

    // Drives one scan of n results; start_at >= 0 re-pulses start alongside that sample.
    task automatic run_scan(input string name, input int n, input int last_pos, input int thr,
                            input bit gaps, input int start_at, input int exp_val,
                            input int exp_lag, input bit exp_found, input bit exp_err);
        logic signed [DW-1:0] ev;
        logic signed [LW-1:0] el;
        logic                 ef, er;
        exp_q.push_back({DW'(exp_val), LW'(exp_lag), exp_found, exp_err});
        @(negedge clk);
        start = 1'b1;
        threshold = DW'(thr);
        @(negedge clk);
        start = 1'b0;
        check({name, ".ready"}, int'(bus.in_ready), 1);
        check({name, ".busy"}, int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = vec[i];
            bus.in_last  = (i == last_pos);
            start        = (i == start_at);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        {ev, el, ef, er} = exp_q.pop_front();
        check({name, ".done"}, int'(done), 1);
        check({name, ".ready_off"}, int'(bus.in_ready), 0);
        check({name, ".val"}, int'(peak_val), int'(ev));
        check({name, ".lag"}, int'(peak_lag), int'(el));
        check({name, ".found"}, int'(found), int'(ef));
        check({name, ".err"}, int'(err), int'(er));
        @(negedge clk);
        check({name, ".done_low"}, int'(done), 0);
        check({name, ".idle"}, int'(dbg_state), 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".ready"}, int'(bus.in_ready), 0);
        check({name, ".busy"}, int'(busy), 0);
        check({name, ".done"}, int'(done), 0);
        check({name, ".val"}, int'(peak_val), 0);
        check({name, ".lag"}, int'(peak_lag), 0);
        check({name, ".found"}, int'(found), 0);
        check({name, ".err"}, int'(err), 0);
        check({name, ".state"}, int'(dbg_state), 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;

        // in_valid while idle must not be consumed
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(100);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        check("idle_valid.ready", int'(bus.in_ready), 0);

        set_vec(1, 2, 3, 9, 3, 2, 1);
        run_scan("centre", 7, 6, 0, 1'b0, -1, 9, 0, 1'b1, 1'b0);
        set_vec(9, 0, 0, 0, 0, 0, 0);
        run_scan("edge_lo", 7, 6, 10, 1'b0, -1, 9, -3, 1'b0, 1'b0);
        set_vec(0, 0, 0, 0, 0, 0, 9);
        run_scan("edge_hi", 7, 6, 9, 1'b0, -1, 9, 3, 1'b1, 1'b0);
        set_vec(5, 7, 7, 1, 1, 1, 1);
        run_scan("tie", 7, 6, 7, 1'b0, -1, 7, -2, 1'b1, 1'b0);
`ifdef XCORR_PEAK_ABS_EN
        set_vec(3, -12, 4, 0, 0, 0, 0);
        run_scan("abs", 7, 6, 0, 1'b0, -1, 12, -2, 1'b1, 1'b0);
        set_vec(0, -32768, 0, 0, 0, 0, 0);
        run_scan("abs_sat", 7, 6, 0, 1'b0, -1, 32767, -2, 1'b1, 1'b0);
`else
        set_vec(-5, -5, -5, -5, -1, -5, -5);
        run_scan("neg_thr0", 7, 6, 0, 1'b0, -1, -1, 1, 1'b0, 1'b0);
        run_scan("neg_thrm2", 7, 6, -2, 1'b0, -1, -1, 1, 1'b1, 1'b0);
`endif
        set_vec(1, 2, 8, 3, 4, 0, 0);
        run_scan("early_last", 5, 4, 0, 1'b0, -1, 8, -1, 1'b1, 1'b1);
        set_vec(1, 2, 3, 9, 3, 2, 1);
        run_scan("no_last", 7, -1, 0, 1'b0, -1, 9, 0, 1'b1, 1'b1);
        run_scan("gaps", 7, 6, 0, 1'b1, -1, 9, 0, 1'b1, 1'b0);
        run_scan("start_in_scan", 7, 6, 0, 1'b0, 3, 9, 0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a scan
        @(negedge clk);
        start = 1'b1;
        threshold = '0;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = vec[0];
        @(negedge clk);
        bus.in_data  = vec[1];
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_state("mid_reset");
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_scan("after_reset", 7, 6, 0, 1'b0, -1, 9, 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
